// File: rtl/card_job_arbiter.sv
// Round-robin owner of one shared matrix card: grants, issues a 1-cycle start, watches rdy with two watchdogs.
// Ack/start 1 cycle after the grant edge, done 1 cycle after rdy returns; requests wait (held level) while busy or card not ready.
module card_job_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDX_W    = $clog2(NREQ),
  parameter int TMO_W    = 20,
  parameter int BUSY_TMO = 15
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req_in,
  input  logic             card_rdy_in,
  output logic [NREQ-1:0]  ack_out,
  output logic [NREQ-1:0]  done_out,
  output logic             err_out,
  output logic             card_start_out,
  output logic             busy_out,
  output logic [IDX_W-1:0] grant_idx_out,
  output logic [7:0]       tmo_cnt_out
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [NREQ-1:0]   ack_d, done_d;
  logic              start_d, err_out_d;
  logic [IDX_W-1:0]  winner, idx;
  logic              grant_ok;
  logic              busy_expired, done_expired;

  assign grant_ok     = (|req_in) & card_rdy_in;
  assign busy_expired = (cnt_q == TMO_W'(BUSY_TMO));
  assign done_expired = &cnt_q;

  // Scan downward so the requester closest after last_q is the final (winning) assignment.
  always_comb begin
    winner = last_q;
    idx    = last_q;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last_q) + i) % NREQ);
      if (req_in[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      grant_q        <= '0;
      last_q         <= IDX_W'(NREQ - 1);
      tmo_q          <= '0;
      ack_out        <= '0;
      done_out       <= '0;
      card_start_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      tmo_q          <= tmo_d;
      ack_out        <= ack_d;
      done_out       <= done_d;
      card_start_out <= start_d;
      err_out        <= err_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_ok) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!card_rdy_in)      state_d = WAIT_DONE;
        else if (busy_expired) state_d = DONE;
      end
      WAIT_DONE: if (card_rdy_in || done_expired) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Done pulse is registered on entry to DONE so it is visible for exactly the DONE cycle.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    ack_d     = '0;
    done_d    = '0;
    start_d   = 1'b0;
    err_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          grant_d = winner;
          ack_d   = NREQ'(1) << winner;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        if (!card_rdy_in) begin
          cnt_d = '0;
        end else if (busy_expired) begin
          err_d     = 1'b1;
          done_d    = NREQ'(1) << grant_q;
          err_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (card_rdy_in) begin
          err_d  = 1'b0;
          done_d = NREQ'(1) << grant_q;
        end else if (done_expired) begin
          err_d     = 1'b1;
          done_d    = NREQ'(1) << grant_q;
          err_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        last_d = grant_q;
        if (err_q && (tmo_q != 8'hff)) tmo_d = tmo_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign busy_out      = (state_q != IDLE);
  assign grant_idx_out = grant_q;
  assign tmo_cnt_out   = tmo_q;

endmodule
